// File: rtl/sdffe_resp_checker_if.sv
// Bundle between an SDFFE stimulus/DUT pair and the response checker.
// master: drives START/D/EN/SRST/Q_DUT; slave: the checker, drives the results.
interface sdffe_resp_checker_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);
    logic             START;
    logic [WIDTH-1:0] D;
    logic             EN;
    logic             SRST;
    logic [WIDTH-1:0] Q_DUT;
    logic [WIDTH-1:0] EXP_Q;
    logic             MISMATCH;
    logic [CNT_W-1:0] SAMPLE_CNT;
    logic [CNT_W-1:0] ERR_CNT;
    logic             BUSY;
    logic             DONE;
`ifdef SDFFE_CHK_FIRST_ERR_EN
    logic             FIRST_ERR_VLD;
    logic [CNT_W-1:0] FIRST_ERR_IDX;
    logic [WIDTH-1:0] FIRST_ERR_EXP;
    logic [WIDTH-1:0] FIRST_ERR_GOT;

    modport master (
        output START, D, EN, SRST, Q_DUT,
        input  EXP_Q, MISMATCH, SAMPLE_CNT, ERR_CNT, BUSY, DONE,
        input  FIRST_ERR_VLD, FIRST_ERR_IDX, FIRST_ERR_EXP, FIRST_ERR_GOT
    );

    modport slave (
        input  START, D, EN, SRST, Q_DUT,
        output EXP_Q, MISMATCH, SAMPLE_CNT, ERR_CNT, BUSY, DONE,
        output FIRST_ERR_VLD, FIRST_ERR_IDX, FIRST_ERR_EXP, FIRST_ERR_GOT
    );
`else
    modport master (
        output START, D, EN, SRST, Q_DUT,
        input  EXP_Q, MISMATCH, SAMPLE_CNT, ERR_CNT, BUSY, DONE
    );

    modport slave (
        input  START, D, EN, SRST, Q_DUT,
        output EXP_Q, MISMATCH, SAMPLE_CNT, ERR_CNT, BUSY, DONE
    );
`endif
endinterface

// File: rtl/sdffe_resp_checker.sv
// Passive SDFFE response checker: golden SDFFE model, per-clock Q compare,
// sample/error counters and an IDLE/RUN/DONE run controller.
// Ports: CLK, ARST_N (async active-low); bus (slave modport) carries
//   START, D, EN, SRST, Q_DUT in and EXP_Q, MISMATCH, SAMPLE_CNT,
//   ERR_CNT, BUSY, DONE out.
// Optional: define SDFFE_CHK_FIRST_ERR_EN to add FIRST_ERR_VLD/IDX/EXP/GOT,
//   a capture of the first mismatching sample of each run.
module sdffe_resp_checker #(
    parameter int               WIDTH       = 2,
    parameter logic [WIDTH-1:0] SRST_VAL    = '0,
    parameter bit               SRST_POL    = 1'b1,
    parameter bit               EN_POL      = 1'b1,
    parameter int               NUM_SAMPLES = 16,
    parameter int               CNT_W       = 8
) (
    input logic                 CLK,
    input logic                 ARST_N,
    sdffe_resp_checker_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] exp_q;
    logic             exp_valid;
    logic             mismatch;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;

    logic             srst_act;
    logic             en_act;
    logic             cmp;
    logic             diff;
    logic             last;

    assign srst_act = (bus.SRST == SRST_POL);
    assign en_act   = (bus.EN == EN_POL);

    // A START edge only clears the run; it never compares.
    assign cmp  = (state == S_RUN) && !bus.START && exp_valid;

    // Case inequality so X/Z on Q_DUT counts as a failure.
    assign diff = (bus.Q_DUT !== exp_q);

    assign last = cmp && ((int'(sample_cnt) + 1) == NUM_SAMPLES);

    // Golden SDFFE: SRST wins over EN; tracks in every state.
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            exp_q     <= '0;
            exp_valid <= 1'b0;
        end else begin
            if (srst_act) begin
                exp_q <= SRST_VAL;
            end else if (en_act) begin
                exp_q <= bus.D;
            end
            if (srst_act || en_act) begin
                exp_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (bus.START) state_nx = S_RUN;
            end
            S_RUN: begin
                if (bus.START)  state_nx = S_RUN;
                else if (last)  state_nx = S_DONE;
            end
            S_DONE: begin
                if (bus.START) state_nx = S_RUN;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            mismatch   <= 1'b0;
        end else if (bus.START) begin
            sample_cnt <= '0;
            err_cnt    <= '0;
            mismatch   <= 1'b0;
        end else if (cmp) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            mismatch   <= diff;
            if (diff && (err_cnt != ERR_MAX)) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end else if (state == S_RUN) begin
            // Nothing loaded yet: DUT Q is meaningless, keep the flag low.
            mismatch <= 1'b0;
        end
    end

    assign bus.EXP_Q      = exp_q;
    assign bus.MISMATCH   = mismatch;
    assign bus.SAMPLE_CNT = sample_cnt;
    assign bus.ERR_CNT    = err_cnt;
    assign bus.BUSY       = (state == S_RUN);
    assign bus.DONE       = (state == S_DONE);

`ifdef SDFFE_CHK_FIRST_ERR_EN
    logic             fe_vld;
    logic [CNT_W-1:0] fe_idx;
    logic [WIDTH-1:0] fe_exp;
    logic [WIDTH-1:0] fe_got;

    // Index is the sample number before this compare (0-based).
    always_ff @(posedge CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            fe_vld <= 1'b0;
            fe_idx <= '0;
            fe_exp <= '0;
            fe_got <= '0;
        end else if (bus.START) begin
            fe_vld <= 1'b0;
            fe_idx <= '0;
            fe_exp <= '0;
            fe_got <= '0;
        end else if (cmp && diff && !fe_vld) begin
            fe_vld <= 1'b1;
            fe_idx <= sample_cnt;
            fe_exp <= exp_q;
            fe_got <= bus.Q_DUT;
        end
    end

    assign bus.FIRST_ERR_VLD = fe_vld;
    assign bus.FIRST_ERR_IDX = fe_idx;
    assign bus.FIRST_ERR_EXP = fe_exp;
    assign bus.FIRST_ERR_GOT = fe_got;
`endif

endmodule

// File: tb/tb_sdffe_resp_checker.sv
// Scoreboard bench for sdffe_resp_checker: directed steps push expected
// snapshots, a negedge monitor pops and compares them when they fall due.
module tb_sdffe_resp_checker;

    logic       clk;
    logic       arst_n;
    logic       start_m;
    logic       start_s;
    logic [1:0] d;
    logic       en;
    logic       srst;
    logic       frc;
    logic [1:0] fval;
    logic [1:0] q_ref;
    int         cyc;
    int         tests;
    int         fails;

    typedef struct {
        int         due;
        int         kind;
        string      name;
        logic [1:0] q;
        logic       mm;
        logic [7:0] sc;
        logic [7:0] ec;
        logic       by;
        logic       dn;
        logic       fv;
        logic [7:0] fi;
        logic [1:0] fe;
        logic [1:0] fg;
    } exp_t;

    exp_t sb[$];
    exp_t ent;

    sdffe_resp_checker_if #(.WIDTH(2), .CNT_W(8)) m_if ();
    sdffe_resp_checker_if #(.WIDTH(2), .CNT_W(8)) s_if ();

    sdffe_resp_checker #(
        .WIDTH(2), .SRST_VAL(2'b00), .SRST_POL(1'b1),
        .EN_POL(1'b1), .NUM_SAMPLES(16), .CNT_W(8)
    ) u_main (
        .CLK(clk), .ARST_N(arst_n), .bus(m_if.slave)
    );

    sdffe_resp_checker #(
        .WIDTH(2), .SRST_VAL(2'b00), .SRST_POL(1'b1),
        .EN_POL(1'b1), .NUM_SAMPLES(400), .CNT_W(8)
    ) u_sat (
        .CLK(clk), .ARST_N(arst_n), .bus(s_if.slave)
    );

    // Behavioural stand-in for a correct SDFFE DUT, with a fault override.
    always @(posedge clk) begin
        if (srst)    q_ref <= 2'b00;
        else if (en) q_ref <= d;
    end

    assign m_if.START = start_m;
    assign m_if.D     = d;
    assign m_if.EN    = en;
    assign m_if.SRST  = srst;
    assign m_if.Q_DUT = frc ? fval : q_ref;

    assign s_if.START = start_s;
    assign s_if.D     = d;
    assign s_if.EN    = en;
    assign s_if.SRST  = srst;
    assign s_if.Q_DUT = 2'b01;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void cmp(string nm, logic [31:0] got, logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endfunction

    // Monitor: compare every snapshot that falls due on this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            ent = sb.pop_front();
            if (ent.due < cyc) begin
                tests++;
                fails++;
                $display("FAIL %s stale entry due %0d at %0d", ent.name, ent.due, cyc);
            end else if (ent.kind == 1) begin
                cmp({ent.name, ".mismatch"}, 32'(s_if.MISMATCH), 32'(ent.mm));
                cmp({ent.name, ".err_cnt"}, 32'(s_if.ERR_CNT), 32'(ent.ec));
                cmp({ent.name, ".busy"}, 32'(s_if.BUSY), 32'(ent.by));
            end else if (ent.kind == 2) begin
`ifdef SDFFE_CHK_FIRST_ERR_EN
                cmp({ent.name, ".fe_vld"}, 32'(m_if.FIRST_ERR_VLD), 32'(ent.fv));
                cmp({ent.name, ".fe_idx"}, 32'(m_if.FIRST_ERR_IDX), 32'(ent.fi));
                cmp({ent.name, ".fe_exp"}, 32'(m_if.FIRST_ERR_EXP), 32'(ent.fe));
                cmp({ent.name, ".fe_got"}, 32'(m_if.FIRST_ERR_GOT), 32'(ent.fg));
                cmp({ent.name, ".err_cnt"}, 32'(m_if.ERR_CNT), 32'(ent.ec));
`endif
            end else begin
                cmp({ent.name, ".exp_q"}, 32'(m_if.EXP_Q), 32'(ent.q));
                cmp({ent.name, ".mismatch"}, 32'(m_if.MISMATCH), 32'(ent.mm));
                cmp({ent.name, ".sample_cnt"}, 32'(m_if.SAMPLE_CNT), 32'(ent.sc));
                cmp({ent.name, ".err_cnt"}, 32'(m_if.ERR_CNT), 32'(ent.ec));
                cmp({ent.name, ".busy"}, 32'(m_if.BUSY), 32'(ent.by));
                cmp({ent.name, ".done"}, 32'(m_if.DONE), 32'(ent.dn));
            end
        end
    end

    task automatic step(input logic stm, input logic sts, input logic [1:0] dd,
                        input logic e, input logic sr, input logic f,
                        input logic [1:0] fv);
        @(posedge clk);
        #1;
        start_m = stm;
        start_s = sts;
        d       = dd;
        en      = e;
        srst    = sr;
        frc     = f;
        fval    = fv;
    endtask

    // lag 1: state after the edge that samples the inputs just driven.
    task automatic chk(input string nm, input int lag, input logic [1:0] q,
                       input logic mm, input int sc, input int ec,
                       input logic by, input logic dn);
        exp_t x;
        x      = '{default: '0, name: nm, kind: 0, due: cyc + lag};
        x.q    = q;
        x.mm   = mm;
        x.sc   = 8'(sc);
        x.ec   = 8'(ec);
        x.by   = by;
        x.dn   = dn;
        sb.push_back(x);
    endtask

    task automatic chk_sat(input string nm, input logic mm, input int ec);
        exp_t x;
        x      = '{default: '0, name: nm, kind: 1, due: cyc + 1};
        x.mm   = mm;
        x.ec   = 8'(ec);
        x.by   = 1'b1;
        sb.push_back(x);
    endtask

    task automatic chk_fe(input string nm, input int idx, input logic [1:0] fe,
                          input logic [1:0] fg, input int ec);
        exp_t x;
        x      = '{default: '0, name: nm, kind: 2, due: cyc + 1};
        x.fv   = 1'b1;
        x.fi   = 8'(idx);
        x.fe   = fe;
        x.fg   = fg;
        x.ec   = 8'(ec);
        sb.push_back(x);
    endtask

    initial begin
        logic [3:0] iv;
        tests   = 0;
        fails   = 0;
        cyc     = 0;
        arst_n  = 1'b0;
        start_m = 1'b0;
        start_s = 1'b0;
        d       = 2'b00;
        en      = 1'b0;
        srst    = 1'b0;
        frc     = 1'b0;
        fval    = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_init", 0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 arst_n = 1'b1;

        // Correct DUT, EN=1, walk SRST/D over 16 samples.
        step(1, 0, 2'b00, 1, 0, 0, 2'b00);
        chk("t2_start", 1, 2'b00, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            iv = 4'(i);
            step(0, 0, iv[1:0], 1, iv[2], 0, 2'b00);
            chk($sformatf("t2_s%0d", i), 1, iv[2] ? 2'b00 : iv[1:0],
                0, i + 1, 0, i < 15, i == 15);
        end
        step(0, 0, 2'b11, 0, 0, 0, 2'b00);
        chk("done_hold", 1, 2'b00, 0, 16, 0, 0, 1);
        step(0, 0, 2'b10, 1, 0, 0, 2'b00);
        chk("done_track", 1, 2'b10, 0, 16, 0, 0, 1);

        // EN=0 phase: only SRST moves the model.
        step(1, 0, 2'b01, 0, 0, 0, 2'b00);
        chk("t3_start", 1, 2'b10, 0, 0, 0, 1, 0);
        step(0, 0, 2'b01, 0, 0, 0, 2'b00);
        chk("t3_hold", 1, 2'b10, 0, 1, 0, 1, 0);
        step(0, 0, 2'b10, 0, 1, 0, 2'b00);
        chk("t3_srst", 1, 2'b00, 0, 2, 0, 1, 0);
        step(0, 0, 2'b11, 0, 0, 0, 2'b00);
        chk("t3_hold2", 1, 2'b00, 0, 3, 0, 1, 0);
        step(0, 0, 2'b00, 0, 1, 0, 2'b00);
        chk("t3_srst2", 1, 2'b00, 0, 4, 0, 1, 0);
        step(0, 0, 2'b01, 0, 0, 0, 2'b00);
        chk("t3_hold3", 1, 2'b00, 0, 5, 0, 1, 0);

        // SRST and EN together: SRST must win; DUT claims 11.
        step(0, 0, 2'b11, 1, 1, 0, 2'b00);
        chk("t4_prio", 1, 2'b00, 0, 6, 0, 1, 0);
        step(0, 0, 2'b11, 0, 0, 1, 2'b11);
        chk("t4_fault", 1, 2'b00, 1, 7, 1, 1, 0);
        step(0, 0, 2'b11, 0, 0, 0, 2'b00);
        chk("t4_clear", 1, 2'b00, 0, 8, 1, 1, 0);

        // Asynchronous abort mid-run.
        repeat (2) @(posedge clk);
        #3 arst_n = 1'b0;
        chk("t1_async", 0, 2'b00, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 arst_n = 1'b1;

        // Nothing loaded after reset: RUN must not compare.
        step(1, 0, 2'b00, 0, 0, 0, 2'b00);
        chk("nv_start", 1, 2'b00, 0, 0, 0, 1, 0);
        step(0, 0, 2'b11, 0, 0, 0, 2'b00);
        chk("nv_nocmp", 1, 2'b00, 0, 0, 0, 1, 0);
        step(0, 0, 2'b01, 1, 0, 0, 2'b00);
        chk("nv_load", 1, 2'b01, 0, 0, 0, 1, 0);
        step(0, 0, 2'b10, 0, 0, 0, 2'b00);
        chk("nv_first", 1, 2'b01, 0, 1, 0, 1, 0);
        step(1, 0, 2'b10, 0, 0, 0, 2'b00);
        chk("run_restart", 1, 2'b01, 0, 0, 0, 1, 0);

`ifdef SDFFE_CHK_FIRST_ERR_EN
        step(1, 0, 2'b00, 1, 0, 0, 2'b00);
        step(0, 0, 2'b01, 1, 0, 0, 2'b00);
        step(0, 0, 2'b11, 1, 0, 0, 2'b00);
        step(0, 0, 2'b00, 1, 0, 0, 2'b00);
        step(0, 0, 2'b01, 1, 0, 0, 2'b00);
        step(0, 0, 2'b10, 1, 0, 0, 2'b00);
        step(0, 0, 2'b11, 1, 0, 1, 2'b00);
        step(0, 0, 2'b01, 1, 0, 0, 2'b00);
        step(0, 0, 2'b10, 1, 0, 1, 2'b11);
        step(0, 0, 2'b10, 0, 0, 0, 2'b00);
        chk_fe("t6_first", 5, 2'b10, 2'b00, 2);
`endif

        // Stuck-at-01 DUT against a 0 model: 300 faults, count clamps at 255.
        step(0, 1, 2'b00, 1, 0, 0, 2'b00);
        for (int k = 1; k <= 300; k++) begin
            step(0, 0, 2'b00, 1, 0, 0, 2'b00);
            if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300) begin
                chk_sat($sformatf("t5_k%0d", k), 1'b1, (k > 255) ? 255 : k);
            end
        end

        repeat (3) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
